lfsr_seq_ctrl: RTL
==================

Name: lfsr_seq_ctrl

Overview:
Controller that sequences the team's 6-bit Fibonacci LFSR (feedback D[4]^D[5] into D[0], polynomial x^6+x^5+1, period 63, serial seed via seed/enable mux).
- Serially loads a 6-bit seed, then lets the LFSR free-run.
- Shares the resulting random values between two requesters using round-robin arbitration.
- Signals period completion.
- The LFSR has no reset, so this block alone determines when its contents are valid.

Parameters:
- PERIOD, 63: RUN cycles per full LFSR sequence; period counter wraps at PERIOD-1.
- ZERO_SUB, 6'h01: seed substituted when seed_val==0.

Ports:
- clk  in  1  rising-edge clock, shared with the LFSR
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: latch seed_val and (re)load the LFSR
- stop  in  1  pulse: return to IDLE
- seed_val  in  6  seed to load
- lfsr_d  in  6  LFSR D[5:0]
- lfsr_seed  out  1  serial seed bit to the LFSR
- lfsr_enable  out  1  LFSR mux select (1 = shift in seed)
- req0, req1  in  1 each  level requests for a random value
- gnt0, gnt1  out  1 each  one-cycle grant pulses
- rnd_out  out  6  random value, valid when either grant is high
- valid  out  1  LFSR contents are known (state RUN)
- busy  out  1  state LOAD
- period_tick  out  1  one-cycle pulse; next lfsr_d equals the loaded seed

Behaviour:
- Reset: rst_n low asynchronously forces IDLE. All of the following clear to 0: outputs, bit counter, period counter, RR pointer (points to req0), latched seed. LFSR contents are not reset and must be reloaded.
- States: IDLE, LOAD, RUN.
- IDLE
  - lfsr_enable=0, valid=0, no grants.
  - start -> LOAD next cycle. Latch seed_val, or ZERO_SUB if seed_val==0. Bit counter = 0.
- LOAD
  - Lasts exactly 6 cycles. lfsr_enable=1, busy=1.
  - lfsr_seed = latched_seed[5-cnt], MSB first.
  - start and stop are ignored. Requests are not granted.
  - After the 6th edge: lfsr_d == latched seed, state -> RUN, period counter = 0.
- RUN
  - lfsr_enable=0, lfsr_seed=0, valid=1. The LFSR advances every cycle.
  - Period counter increments each cycle and wraps at PERIOD-1. period_tick is high while count==PERIOD-1.
  - start -> LOAD (reseed; new seed latched). stop -> IDLE.
  - If start and stop are high in the same cycle, start wins.
- Arbitration (RUN only, combinational on req/pointer/lfsr_d)
  - At most one grant per cycle. rnd_out = lfsr_d in the grant cycle; rnd_out = 0 otherwise.
  - Only one requester high: grant it.
  - Both high: grant the requester the pointer names.
  - After any grant, the pointer moves to the other requester on the next edge.
  - Sustained dual requests therefore alternate 0,1,0,1. Each consumed value is distinct in consecutive cycles.
- A grant can never coincide with LOAD or IDLE. In the cycle start is sampled in RUN, grants are still issued, since the state is still RUN.
- Reset mid-LOAD or mid-RUN: immediate IDLE, valid=0. A new start is required.

Optional Feature:
LFSR_LOCKUP_RECOVER_EN
- Defined: in RUN, lfsr_d==6'h00 (illegal lock-up, e.g. a glitch) suppresses grants that cycle. It forces LOAD with the latched seed on the next edge and pulses output lockup_err (1 bit, present only when defined) for one cycle.
- Undefined: no check, no lockup_err port. A zero state persists until the next start.

Test Plan:
1. Reset, then start with seed_val=6'h2D -> busy for 6 cycles, lfsr_seed sequence 1,0,1,1,0,1, lfsr_enable=1. First RUN cycle: lfsr_d=6'h2D, valid=1. Next cycle: 6'h1B.
2. seed_val=6'h00 + start -> lfsr_seed sequence 0,0,0,0,0,1; first RUN value 6'h01.
3. Seed 6'h2D, run 63 cycles -> period_tick exactly once, at RUN cycle 63. The following cycle lfsr_d=6'h2D. Tick repeats every 63 cycles.
4. req0=req1=1 held in RUN from reset pointer -> gnt0,gnt1,gnt0,gnt1. rnd_out equals lfsr_d each cycle (6'h2D, 6'h1B, ...). Never both grants high.
5. req0 held through start pulse in RUN -> grant in the start cycle, none for 6 LOAD cycles, grants resume in first RUN cycle with the new seed. start/stop during LOAD ignored.
6. rst_n low mid-LOAD (cycle 3) -> outputs 0 immediately. With LFSR_LOCKUP_RECOVER_EN, force lfsr_d=0 in RUN -> lockup_err pulse, no grant, 6-cycle reload.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: sequencer for the 6-bit Fibonacci LFSR (x^6+x^5+1).
// Serially loads a seed (MSB first) through the LFSR seed/enable mux,
// lets the LFSR free-run, shares its values between two requesters with
// round-robin arbitration and flags each completed period.
// The LFSR itself has no reset; valid is the only indication that its
// contents are meaningful.
// Optional build macro: LFSR_LOCKUP_RECOVER_EN adds an all-zero lock-up
// detector that reloads the latched seed and pulses lockup_err.
module lfsr_seq_ctrl #(
    parameter int          PERIOD   = 63,
    parameter logic [5:0]  ZERO_SUB = 6'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [5:0] seed_val,
    input  logic [5:0] lfsr_d,
    output logic       lfsr_seed,
    output logic       lfsr_enable,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [5:0] rnd_out,
    output logic       valid,
    output logic       busy,
    output logic       period_tick
`ifdef LFSR_LOCKUP_RECOVER_EN
    ,
    output logic       lockup_err
`endif
);

    localparam int PW = $clog2(PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_idx;
    logic [PW-1:0]   per_cnt;
    logic            ptr;       // 0: req0 wins a tie, 1: req1 wins a tie
    logic [5:0]      seed_q;
    logic            load_req;  // latch a new seed this cycle
    logic            lockup;

    // State register; reset forces IDLE regardless of the LFSR contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode, LFSR mux control and round-robin grants
    always_comb begin
        state_nx    = state;
        load_req    = 1'b0;
        lockup      = 1'b0;
        lfsr_enable = 1'b0;
        lfsr_seed   = 1'b0;
        busy        = 1'b0;
        valid       = 1'b0;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rnd_out     = 6'h00;
        period_tick = 1'b0;
        bit_idx     = 3'd5 - bit_cnt;

`ifdef LFSR_LOCKUP_RECOVER_EN
        lockup = (state == RUN) && (lfsr_d == 6'h00);
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    load_req = 1'b1;
                end
            end
            LOAD: begin
                // start/stop are deliberately ignored until the seed is in
                lfsr_enable = 1'b1;
                busy        = 1'b1;
                lfsr_seed   = seed_q[bit_idx];
                if (bit_cnt == 3'd5) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                valid       = 1'b1;
                period_tick = (per_cnt == PW'(PERIOD - 1));
                // start outranks stop; a reseed also clears a lock-up
                if (start) begin
                    state_nx = LOAD;
                    load_req = 1'b1;
                end else if (stop) begin
                    state_nx = IDLE;
                end else if (lockup) begin
                    state_nx = LOAD;
                end
                // A zero LFSR value is never handed out
                if (!lockup) begin
                    if (req0 && req1) begin
                        gnt0 = ~ptr;
                        gnt1 = ptr;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                    if (gnt0 || gnt1) begin
                        rnd_out = lfsr_d;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign lockup_err = lockup;
`endif

    // Seed latch, serial bit counter, period counter and RR pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q  <= 6'h00;
            bit_cnt <= 3'd0;
            per_cnt <= '0;
            ptr     <= 1'b0;
        end else begin
            // An all-zero seed would lock the LFSR, so substitute
            if (load_req) begin
                seed_q <= (seed_val == 6'h00) ? ZERO_SUB : seed_val;
            end

            if (state == LOAD && bit_cnt != 3'd5) begin
                bit_cnt <= bit_cnt + 3'd1;
            end else begin
                bit_cnt <= 3'd0;
            end

            // Held at 0 outside RUN so the first RUN cycle is count 0
            if (state == RUN) begin
                if (per_cnt == PW'(PERIOD - 1)) begin
                    per_cnt <= '0;
                end else begin
                    per_cnt <= per_cnt + PW'(1);
                end
            end else begin
                per_cnt <= '0;
            end

            if (gnt0) begin
                ptr <= 1'b1;
            end else if (gnt1) begin
                ptr <= 1'b0;
            end
        end
    end

endmodule
